// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo
// Receive side of the UART link: synchronizes the asynchronous rx line,
// qualifies the start bit at its midpoint, shifts in 8 data bits LSB first,
// checks the stop bit and presents the byte with a one-cycle valid strobe.
//
// State table
//   state     | meaning
//   IDLE      | line idle, waiting for a falling edge on rx_s
//   START     | timing to the middle of the start bit, glitch reject there
//   DATA      | sampling 8 data bits at mid-bit, LSB first
//   STOP      | sampling the stop bit at mid-bit
//   WAIT_HIGH | stop bit was low; hold off until the line returns high
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   rx_in        asynchronous serial line, idle high
//   data_out     last correctly framed byte, held until the next good frame
//   data_valid   one-cycle pulse, data_out updated on the same cycle
//   framing_err  one-cycle pulse, stop bit sampled low
//   busy         high whenever the FSM is not in IDLE
module uart_rx_sipo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    sh, sh_nxt;
  logic [7:0]    data_out_nxt;
  logic          data_valid_nxt;
  logic          framing_err_nxt;

  // Synchronizer resets to all ones so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      sh          <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      clk_cnt     <= clk_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      sh          <= sh_nxt;
      data_out    <= data_out_nxt;
      data_valid  <= data_valid_nxt;
      framing_err <= framing_err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    clk_cnt_nxt     = clk_cnt;
    bit_idx_nxt     = bit_idx;
    sh_nxt          = sh;
    data_out_nxt    = data_out;
    data_valid_nxt  = 1'b0;
    framing_err_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
        end
      end

      START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end

      // Counting a full bit period from mid start bit lands each sample
      // in the middle of the following bit.
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          sh_nxt      = {rx_s, sh[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end

      // Leaving at mid stop bit leaves half a bit of margin for a
      // back-to-back start edge.
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          if (rx_s) begin
            data_out_nxt   = sh;
            data_valid_nxt = 1'b1;
            state_nxt      = IDLE;
          end else begin
            framing_err_nxt = 1'b1;
            state_nxt       = WAIT_HIGH;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end

      WAIT_HIGH: begin
        clk_cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt   = IDLE;
        clk_cnt_nxt = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_sipo.sv
module tb_uart_rx_sipo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_err;
  logic       busy;

  uart_rx_sipo #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] v_data[$];
  int         v_cyc[$];
  int         fe_cnt = 0;
  int         both_cnt = 0;
  int         busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs observed on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (data_valid) begin
      v_data.push_back(data_out);
      v_cyc.push_back(cyc);
    end
    if (framing_err) fe_cnt++;
    if (data_valid && framing_err) both_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first and stop, each CPB cycles wide.
  // rst_bit >= 0 pulses rst mid-way through that bit slot (0 = start bit)
  // and abandons the frame with the line returned high.
  task automatic send_frame(input logic [7:0] b, input logic stop_b,
                            input int rst_bit, output int start_cyc);
    logic [9:0] bits;
    bits      = {stop_b, b, 1'b0};
    start_cyc = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      for (int c = 0; c < CPB; c++) begin
        if (i == rst_bit && c == 8) begin
          rst = 1'b1;
          tick(1);
          rst   = 1'b0;
          rx_in = 1'b1;
          return;
        end
        tick(1);
      end
    end
  endtask

  int sc, sc2, b0, f0;

  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    tick(3);
    rst = 1'b0;
    check_val("rst_data_out", int'(data_out), 8'h00);
    check_val("rst_valid", int'(data_valid), 0);
    check_val("rst_ferr", int'(framing_err), 0);
    check_val("rst_busy", int'(busy), 0);

    b0 = busy_cnt;
    f0 = fe_cnt;
    tick(100);
    check_val("idle_valid_cnt", v_data.size(), 0);
    check_val("idle_ferr_cnt", fe_cnt - f0, 0);
    check_val("idle_busy_cnt", busy_cnt - b0, 0);
    check_val("idle_data_out", int'(data_out), 8'h00);

    // 0xA5: valid 154 cycles after the first posedge that sees rx_in low
    b0 = busy_cnt;
    f0 = fe_cnt;
    send_frame(8'hA5, 1'b1, -1, sc);
    tick(20);
    check_val("a5_valid_cnt", v_data.size(), 1);
    if (v_data.size() >= 1) begin
      check_val("a5_data", int'(v_data[0]), 8'hA5);
      check_val("a5_latency_in_range",
                int'((v_cyc[0] - sc) >= 153 && (v_cyc[0] - sc) <= 155), 1);
    end
    check_val("a5_ferr_cnt", fe_cnt - f0, 0);
    check_val("a5_busy_cycles", busy_cnt - b0, 152);
    check_val("a5_busy_after", int'(busy), 0);
    v_data.delete();
    v_cyc.delete();

    // back-to-back 0x00 then 0xFF, no idle gap
    f0 = fe_cnt;
    send_frame(8'h00, 1'b1, -1, sc);
    send_frame(8'hFF, 1'b1, -1, sc2);
    tick(20);
    check_val("b2b_valid_cnt", v_data.size(), 2);
    if (v_data.size() == 2) begin
      check_val("b2b_data0", int'(v_data[0]), 8'h00);
      check_val("b2b_data1", int'(v_data[1]), 8'hFF);
      check_val("b2b_gap", v_cyc[1] - v_cyc[0], 160);
    end
    check_val("b2b_ferr_cnt", fe_cnt - f0, 0);
    check_val("b2b_data_out", int'(data_out), 8'hFF);
    v_data.delete();
    v_cyc.delete();

    // glitch: 4 low cycles, rejected at mid start bit
    b0 = busy_cnt;
    f0 = fe_cnt;
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    tick(30);
    check_val("glitch_valid_cnt", v_data.size(), 0);
    check_val("glitch_ferr_cnt", fe_cnt - f0, 0);
    check_val("glitch_busy_cycles", busy_cnt - b0, 8);
    check_val("glitch_busy_after", int'(busy), 0);

    // framing error: 0x3C with stop low, line then held low 40 cycles
    f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1, sc);
    tick(40);
    check_val("ferr_pulse_cnt", fe_cnt - f0, 1);
    check_val("ferr_valid_cnt", v_data.size(), 0);
    check_val("ferr_data_out_kept", int'(data_out), 8'hFF);
    check_val("ferr_busy_while_low", int'(busy), 1);
    rx_in = 1'b1;
    tick(5);
    check_val("ferr_busy_released", int'(busy), 0);
    send_frame(8'h5A, 1'b1, -1, sc);
    tick(20);
    check_val("post_ferr_valid_cnt", v_data.size(), 1);
    if (v_data.size() >= 1) check_val("post_ferr_data", int'(v_data[0]), 8'h5A);
    check_val("post_ferr_fe_cnt", fe_cnt - f0, 1);
    v_data.delete();
    v_cyc.delete();

    // reset pulse during data bit 4 of 0x12 (slot 5 counting the start bit)
    f0 = fe_cnt;
    send_frame(8'h12, 1'b1, 5, sc);
    check_val("midrst_data_out", int'(data_out), 8'h00);
    check_val("midrst_busy", int'(busy), 0);
    tick(200);
    check_val("midrst_valid_cnt", v_data.size(), 0);
    check_val("midrst_ferr_cnt", fe_cnt - f0, 0);
    check_val("midrst_data_out_hold", int'(data_out), 8'h00);
    send_frame(8'h81, 1'b1, -1, sc);
    tick(20);
    check_val("post_rst_valid_cnt", v_data.size(), 1);
    if (v_data.size() >= 1) check_val("post_rst_data", int'(v_data[0]), 8'h81);
    check_val("post_rst_data_out", int'(data_out), 8'h81);

    check_val("valid_ferr_overlap", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
- UART receive path: serial-in, parallel-out deserializer for the receiver side of the UART link.
- Samples an asynchronous rx line and detects the start bit.
- Shifts in 8 data bits, LSB first, matching transmitter bit order.
- Checks the stop bit, presents the byte on a parallel bus with a one-cycle valid strobe, and flags framing errors.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit period; must be even and >= 4 (e.g. 868 for 100 MHz / 115200 baud).
- SYNC_STAGES, 2, flops in the rx_in metastability synchronizer; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- rx_in  input  1  asynchronous serial line; idle high.
- data_out  output  8  last correctly framed byte; holds until the next good frame.
- data_valid  output  1  one-cycle pulse; data_out updated on the same cycle.
- framing_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values (rst sampled high at posedge clk):
  - data_out=8'h00, data_valid=0, framing_err=0, busy=0.
  - state=IDLE, counters=0, shift register=0.
  - All synchronizer flops = 1 (line idle).
- Reset mid-frame aborts the frame immediately. No data_valid and no framing_err are issued for the aborted frame.
- rx_s is the SYNC_STAGES-delayed rx_in. All decisions use rx_s only.
- Counters:
  - clk_cnt counts 0..CLKS_PER_BIT-1.
  - bit_idx counts 0..7, 3 bits.
  - Shift register: sh <= {rx_s, sh[7:1]} on each data sample, so the first received bit lands in bit 0.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE:
    - rx_s==0 -> START, clk_cnt=0.
  - START:
    - clk_cnt increments.
    - At clk_cnt==CLKS_PER_BIT/2-1 (mid start bit): rx_s==0 -> DATA, clk_cnt=0, bit_idx=0.
    - At that same point, rx_s==1 -> IDLE (glitch reject, no outputs).
  - DATA:
    - At clk_cnt==CLKS_PER_BIT-1: sample rx_s into sh, clk_cnt=0.
    - If bit_idx==7 -> STOP; else bit_idx++.
  - STOP:
    - At clk_cnt==CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: data_out<=sh, data_valid=1 for exactly one cycle, then -> IDLE.
    - rx_s==0: framing_err=1 for one cycle, data_out unchanged, then -> WAIT_HIGH.
  - WAIT_HIGH:
    - Stays until rx_s==1, then -> IDLE.
    - Prevents a break or low line from retriggering reception.
- Latency: data_valid asserts SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk cycles (+/-1) after the first posedge sampling rx_in=0.
- Back-to-back frames:
  - Return to IDLE occurs mid stop bit.
  - A start edge arriving at the nominal stop-bit end is accepted with no lost frame.
- data_valid and framing_err are never high on the same cycle.
- Neither can be high while rst is high.
- No flow control: a new data_valid overwrites data_out regardless of the consumer.

Test Plan:
Bench uses CLKS_PER_BIT=16, SYNC_STAGES=2, and drives bits exactly 16 clk wide.
- Reset then idle-high line for 100 cycles -> data_out=8'h00, data_valid/framing_err/busy all 0 throughout.
- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1):
  - data_out=8'hA5 with a single-cycle data_valid ~154 cycles after the start edge (+/-1).
  - framing_err=0; busy high from start detect to the valid cycle.
- Back-to-back 0x00 then 0xFF with no idle gap -> two data_valid pulses 160 cycles apart; data_out=8'h00 then 8'hFF.
- Glitch: rx_in low for 4 cycles then high -> busy pulses briefly, no data_valid, no framing_err, FSM back in IDLE.
- Framing error: 0x3C frame with stop bit 0, then line held low 40 cycles, then high:
  - framing_err single pulse; data_out retains the prior value (0xFF).
  - busy stays high until the line returns high.
  - A following clean 0x5A frame is received correctly.
- Reset mid-frame: rst asserted for 1 cycle during data bit 4 of 0x12 -> no data_valid and no framing_err for that frame, data_out=8'h00; a subsequent 0x81 frame yields data_out=8'h81.
